stage_one_fetch: RTL and testbench
==================================

Name: stage_one_fetch

Overview:
- Instruction-fetch stage (IF) directly upstream of the decode stage.
- Owns the program counter and drives a request/acknowledge instruction-memory port.
- Holds the IF/ID instruction register that decode consumes.
- Applies redirects (branch, jump, register, exception) requested by decode via pcSrc/PCWrite, including a stall buffer and discard of in-flight fetches.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, redirect target for pcSrc=4
NOP_WORD, 32'h0000_0000, instruction value presented when inst_valid=0

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
pcSrc  input  3  next-PC select from decode control
PCWrite  input  1  redirect strobe from decode; qualifies pcSrc
jump_jpc  input  32  shifted jump field; bits [27:0] used
branch_offset  input  32  sign-extended branch word (not shifted)
reg_target  input  32  register-indirect target
stall  input  1  decode cannot accept a new instruction this cycle
imem_req  output  1  instruction-memory request
imem_addr  output  32  fetch address (current PC)
imem_ack  input  1  read data valid this cycle; may arrive in the same cycle as req
imem_rdata  input  32  fetched instruction word
instruction  output  32  IF/ID instruction register
pc_out  output  32  PC of the word in the instruction register
pc_plus4  output  32  pc_out + 4, combinational
inst_valid  output  1  instruction register holds a real instruction

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VECTOR, instruction=NOP_WORD, pc_out=RESET_VECTOR, inst_valid=0.
  - hold buffer cleared; state=REQ; imem_req=0 while reset is asserted.
  - On release, a fetch of RESET_VECTOR is requested on the first clock edge.
- State REQ:
  - imem_req=1, imem_addr=pc.
  - imem_ack & !stall: instruction<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+4.
  - imem_ack & stall: hold<=imem_rdata, hold_pc<=pc, pc<=pc+4, go HOLD. The IF/ID register is unchanged.
  - !imem_ack & !stall: inst_valid<=0, instruction<=NOP_WORD (bubble).
  - !imem_ack & stall: IF/ID register unchanged.
- State HOLD:
  - imem_req=0.
  - When stall drops: instruction<=hold, pc_out<=hold_pc, inst_valid<=1, go REQ.
- State DROP:
  - imem_req=1 with the old address held, waiting for the abandoned fetch to complete.
  - On imem_ack: data discarded, go REQ.
  - Always two or more cycles before any new fetch.
- Redirect: PCWrite=1 with pcSrc in 1..4.
  - Targets:
    - pcSrc=1 (branch): target = pc_plus4 + (branch_offset<<2), modulo 2^32.
    - pcSrc=2 (jump): target = {pc_plus4[31:28], jump_jpc[27:0]}.
    - pcSrc=3 (register): target = reg_target.
    - pcSrc=4 (exception): target = EXC_VECTOR.
    - pcSrc=0 or 5..7: not a redirect; normal sequencing.
  - Actions: pc<=target, instruction<=NOP_WORD, inst_valid<=0, hold buffer discarded.
  - Next state:
    - REQ without ack: go DROP.
    - REQ with same-cycle ack: data dropped, stay REQ.
    - HOLD: go REQ.
    - DROP: stay DROP.
- Priority: rst > redirect > stall > normal fetch. A redirect overrides stall.
- PC arithmetic wraps modulo 2^32. 32'hFFFF_FFFC + 4 = 0; no flag.
- Latency:
  - Zero-wait memory: address issued in cycle N, instruction valid at decode from cycle N+1.
  - Sustained throughput is 1 instruction per cycle.
  - Redirect penalty with zero-wait memory: 1 bubble.

Optional Feature:
Macro: FETCH_ALIGN_CHECK_EN
- Defined:
  - A redirect target with bits [1:0] != 0 is not taken.
  - pc<=EXC_VECTOR instead, and a registered output align_fault pulses 1 for one cycle.
  - align_fault resets to 0.
- Undefined: no align_fault port; target bits [1:0] are forced to 0 before loading pc.

Test Plan:
- Reset release with zero-wait memory returning rdata=addr: imem_addr sequence 0,4,8,C; instruction=0 then 4 one cycle later; inst_valid=1 from second edge.
- Two wait states per fetch (ack on third request cycle): inst_valid pattern 0,0,1 repeating; pc_out 0,4,8 with no skipped address.
- Stall asserted for 3 cycles while ack arrives: instruction held; fetched word buffered (HOLD, imem_req=0); released with correct pc_out and no duplicate or lost word.
- Jump: pc_out=0x1000_0010, PCWrite=1, pcSrc=2, jump_jpc=0x0000_0400: next imem_addr=0x1000_0400; one bubble (inst_valid=0).
- Branch with outstanding fetch: pc_out=0x20, branch_offset=0xFFFF_FFFE, ack delayed 2 cycles: DROP until ack, stale data discarded, next imem_addr=0x1C.
- With FETCH_ALIGN_CHECK_EN: pcSrc=3, reg_target=0x102: align_fault=1 for one cycle; next imem_addr=0x80. Without macro: next imem_addr=0x100.

Source files
------------

// File: rtl/stage_one_fetch.sv
// -----------------------------------------------------------------------------
// stage_one_fetch -- instruction-fetch (IF) stage ahead of decode.
//
// Owns the program counter, drives a request/acknowledge instruction-memory
// port and holds the IF/ID instruction register that decode consumes.
// Decode redirects the PC with PCWrite/pcSrc (branch, jump, register,
// exception). A fetch that completes while decode is stalled is parked in a
// hold buffer. A fetch still outstanding at a redirect is drained and
// discarded in the DROP state.
//
// Optional build macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target vectors to EXC_VECTOR and the
//               align_fault output pulses high for one cycle.
//   undefined : no align_fault port; target bits [1:0] are forced to zero.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   pcSrc[2:0]     next-PC select (1 branch, 2 jump, 3 register, 4 exception)
//   PCWrite        redirect strobe, qualifies pcSrc
//   jump_jpc[31:0] shifted jump field, bits [27:0] used
//   branch_offset  sign-extended branch word (shifted left by 2 internally)
//   reg_target     register-indirect target
//   stall          decode cannot accept a new instruction this cycle
//   imem_req       instruction-memory request
//   imem_addr      fetch address
//   imem_ack       read data valid (may coincide with imem_req)
//   imem_rdata     fetched instruction word
//   instruction    IF/ID instruction register
//   pc_out         PC of the word in the instruction register
//   pc_plus4       pc_out + 4 (combinational)
//   inst_valid     instruction register holds a real instruction
//   align_fault    (FETCH_ALIGN_CHECK_EN only) one-cycle misaligned-target pulse
// -----------------------------------------------------------------------------
module stage_one_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pcSrc,
    input  logic        PCWrite,
    input  logic [31:0] jump_jpc,
    input  logic [31:0] branch_offset,
    input  logic [31:0] reg_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        inst_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        align_fault
`endif
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state_r, state_n;
    logic [31:0] pc_r, pc_n;
    logic [31:0] drop_addr_r, drop_addr_n;
    logic [31:0] hold_r, hold_n;
    logic [31:0] hold_pc_r, hold_pc_n;
    logic [31:0] inst_r, inst_n;
    logic [31:0] pc_out_r, pc_out_n;
    logic        valid_r, valid_n;
    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] load_pc_s;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s  = pc_out_r + 32'd4;
    assign pc_plus4    = pc_plus4_s;
    assign instruction = inst_r;
    assign pc_out      = pc_out_r;
    assign inst_valid  = valid_r;

    // Memory port: no request in HOLD or while reset is held; in DROP the
    // abandoned address stays on the bus until its ack drains it.
    assign imem_req  = rst & (state_r != ST_HOLD);
    assign imem_addr = (state_r == ST_DROP) ? drop_addr_r : pc_r;

    // Decode the redirect request and select its raw target.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = pc_r;
        if (PCWrite) begin
            case (pcSrc)
                3'd1: begin
                    redirect_s = 1'b1;
                    target_s   = pc_plus4_s + (branch_offset << 2);
                end
                3'd2: begin
                    redirect_s = 1'b1;
                    target_s   = {pc_plus4_s[31:28], jump_jpc[27:0]};
                end
                3'd3: begin
                    redirect_s = 1'b1;
                    target_s   = reg_target;
                end
                3'd4: begin
                    redirect_s = 1'b1;
                    target_s   = EXC_VECTOR;
                end
                default: begin
                    redirect_s = 1'b0;
                    target_s   = pc_r;
                end
            endcase
        end else begin
            redirect_s = 1'b0;
            target_s   = pc_r;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_s;
    logic align_fault_r;
    logic unused_s;

    assign misalign_s  = redirect_s & (target_s[1:0] != 2'b00);
    assign load_pc_s   = misalign_s ? EXC_VECTOR : target_s;
    assign align_fault = align_fault_r;
    assign unused_s    = ^jump_jpc[31:28];

    // One-cycle pulse flagging a misaligned redirect that was vectored away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            align_fault_r <= 1'b0;
        end else begin
            align_fault_r <= misalign_s;
        end
    end
`else
    logic unused_s;

    assign load_pc_s = {target_s[31:2], 2'b00};
    assign unused_s  = ^{jump_jpc[31:28], target_s[1:0]};
`endif

    // Next-state logic: redirect outranks stall, stall outranks normal fetch.
    always_comb begin
        state_n     = state_r;
        pc_n        = pc_r;
        drop_addr_n = drop_addr_r;
        hold_n      = hold_r;
        hold_pc_n   = hold_pc_r;
        inst_n      = inst_r;
        pc_out_n    = pc_out_r;
        valid_n     = valid_r;
        if (redirect_s) begin
            pc_n      = load_pc_s;
            inst_n    = NOP_WORD;
            valid_n   = 1'b0;
            hold_n    = NOP_WORD;
            hold_pc_n = RESET_VECTOR;
            case (state_r)
                ST_REQ: begin
                    if (imem_ack) begin
                        state_n = ST_REQ;          // data arrived now; just drop it
                    end else begin
                        state_n     = ST_DROP;
                        drop_addr_n = pc_r;         // keep the abandoned address
                    end
                end
                ST_HOLD: state_n = ST_REQ;
                ST_DROP: state_n = ST_DROP;
                default: state_n = ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (imem_ack) begin
                        pc_n = pc_r + 32'd4;
                        if (stall) begin
                            hold_n    = imem_rdata;
                            hold_pc_n = pc_r;
                            state_n   = ST_HOLD;
                        end else begin
                            inst_n   = imem_rdata;
                            pc_out_n = pc_r;
                            valid_n  = 1'b1;
                        end
                    end else if (!stall) begin
                        inst_n  = NOP_WORD;
                        valid_n = 1'b0;
                    end else begin
                        state_n = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        inst_n   = hold_r;
                        pc_out_n = hold_pc_r;
                        valid_n  = 1'b1;
                        state_n  = ST_REQ;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_n = ST_REQ;
                    end else begin
                        state_n = ST_DROP;
                    end
                end
                default: state_n = ST_REQ;
            endcase
        end
    end

    // Fetch state, PC, hold buffer and IF/ID register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_REQ;
            pc_r        <= RESET_VECTOR;
            drop_addr_r <= RESET_VECTOR;
            hold_r      <= NOP_WORD;
            hold_pc_r   <= RESET_VECTOR;
            inst_r      <= NOP_WORD;
            pc_out_r    <= RESET_VECTOR;
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            pc_r        <= pc_n;
            drop_addr_r <= drop_addr_n;
            hold_r      <= hold_n;
            hold_pc_r   <= hold_pc_n;
            inst_r      <= inst_n;
            pc_out_r    <= pc_out_n;
            valid_r     <= valid_n;
        end
    end

endmodule

// File: tb/tb_stage_one_fetch.sv
// -----------------------------------------------------------------------------
// tb_stage_one_fetch -- self-checking bench for stage_one_fetch.
// A small memory model answers with rdata = address after a programmable
// number of wait states. Expected (pc, word) pairs are queued as stimulus is
// driven and popped whenever decode consumes an instruction
// (inst_valid & !stall at a rising edge).
// -----------------------------------------------------------------------------
module tb_stage_one_fetch;

    logic        clk;
    logic        rst;
    logic [2:0]  pcSrc;
    logic        PCWrite;
    logic [31:0] jump_jpc;
    logic [31:0] branch_offset;
    logic [31:0] reg_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        inst_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          wait_states;
    int          wcnt;
    logic [31:0] sb_q[$];
    logic [31:0] exp_al;

    stage_one_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pcSrc         (pcSrc),
        .PCWrite       (PCWrite),
        .jump_jpc      (jump_jpc),
        .branch_offset (branch_offset),
        .reg_target    (reg_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .inst_valid    (inst_valid)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .align_fault   (align_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack once the request has waited wait_states cycles.
    always_comb begin
        imem_ack   = imem_req && (wcnt >= wait_states);
        imem_rdata = imem_addr;
    end

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: decode consumes the IF/ID word on the coming edge.
    always @(negedge clk) begin
        if (rst && inst_valid && !stall) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_extra", {31'd0, inst_valid}, 32'd0);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                check_eq("sb_pc", pc_out, e);
                check_eq("sb_inst", instruction, e);
            end
        end
    end

    initial begin
        wcnt = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_al = 32'h0000_0080;
`else
        exp_al = 32'h0000_0100;
`endif
        rst = 1'b0; stall = 1'b0; PCWrite = 1'b0; pcSrc = 3'd0;
        jump_jpc = 32'd0; branch_offset = 32'd0; reg_target = 32'd0;
        wait_states = 0;
        tick(); tick();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_pcout", pc_out, 32'h0);
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst", instruction, 32'h0);

        // Zero-wait streaming from the reset vector.
        rst = 1'b1;
        #1;
        check_eq("rel_req", {31'd0, imem_req}, 32'd1);
        sb_q.push_back(32'h0); sb_q.push_back(32'h4);
        sb_q.push_back(32'h8); sb_q.push_back(32'hC);
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_addr", imem_addr, 32'(4 * i));
            tick();
            check_eq("seq_valid", {31'd0, inst_valid}, 32'd1);
        end

        // Two wait states per fetch.
        wait_states = 2;
        sb_q.push_back(32'h10); sb_q.push_back(32'h14); sb_q.push_back(32'h18);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq("ws_valid", {31'd0, inst_valid}, (i % 3 == 2) ? 32'd1 : 32'd0);
        end

        // Stall for three edges while a zero-wait ack arrives.
        wait_states = 0;
        stall = 1'b1;
        tick();
        check_eq("hold_req", {31'd0, imem_req}, 32'd0);
        check_eq("hold_pcout", pc_out, 32'h18);
        tick();
        check_eq("hold_req2", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("hold_inst", instruction, 32'h18);
        stall = 1'b0;
        sb_q.push_back(32'h1C); sb_q.push_back(32'h20);
        tick();
        check_eq("unhold_pcout", pc_out, 32'h1C);
        check_eq("unhold_req", {31'd0, imem_req}, 32'd1);
        check_eq("unhold_addr", imem_addr, 32'h20);
        tick();

        // Register redirect to 0x1000_0010, then jump.
        PCWrite = 1'b1; pcSrc = 3'd3; reg_target = 32'h1000_0010;
        tick();
        PCWrite = 1'b0;
        check_eq("reg_bubble", {31'd0, inst_valid}, 32'd0);
        check_eq("reg_addr", imem_addr, 32'h1000_0010);
        sb_q.push_back(32'h1000_0010);
        tick();
        PCWrite = 1'b1; pcSrc = 3'd2; jump_jpc = 32'h0000_0400;
        tick();
        PCWrite = 1'b0;
        check_eq("jmp_addr", imem_addr, 32'h1000_0400);
        check_eq("jmp_bubble", {31'd0, inst_valid}, 32'd0);
        sb_q.push_back(32'h1000_0400);
        tick();

        // Branch back with a fetch outstanding (two wait states).
        PCWrite = 1'b1; pcSrc = 3'd3; reg_target = 32'h20;
        tick();
        PCWrite = 1'b0;
        sb_q.push_back(32'h20);
        tick();
        wait_states = 2;
        PCWrite = 1'b1; pcSrc = 3'd1; branch_offset = 32'hFFFF_FFFE;
        tick();
        PCWrite = 1'b0;
        check_eq("drop_req", {31'd0, imem_req}, 32'd1);
        check_eq("drop_addr", imem_addr, 32'h24);
        check_eq("drop_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("drop_addr2", imem_addr, 32'h24);
        tick();
        check_eq("br_addr", imem_addr, 32'h1C);
        check_eq("br_valid", {31'd0, inst_valid}, 32'd0);
        wait_states = 0;
        sb_q.push_back(32'h1C);
        tick();

        // Misaligned register target.
        PCWrite = 1'b1; pcSrc = 3'd3; reg_target = 32'h102;
        tick();
        PCWrite = 1'b0;
        check_eq("al_addr", imem_addr, exp_al);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("al_fault", {31'd0, align_fault}, 32'd1);
`endif
        sb_q.push_back(exp_al);
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("al_fault_clr", {31'd0, align_fault}, 32'd0);
`endif

        // PC wrap at the top of the address space.
        PCWrite = 1'b1; pcSrc = 3'd3; reg_target = 32'hFFFF_FFFC;
        tick();
        PCWrite = 1'b0;
        sb_q.push_back(32'hFFFF_FFFC);
        tick();
        check_eq("wrap_addr", imem_addr, 32'h0);
        check_eq("wrap_plus4", pc_plus4, 32'h0);

        // Exception vector.
        PCWrite = 1'b1; pcSrc = 3'd4;
        tick();
        PCWrite = 1'b0;
        check_eq("exc_addr", imem_addr, 32'h80);
        sb_q.push_back(32'h80);
        tick();

        // pcSrc=5 with PCWrite is not a redirect.
        PCWrite = 1'b1; pcSrc = 3'd5;
        tick();
        PCWrite = 1'b0;
        check_eq("nored_pcout", pc_out, 32'h84);
        check_eq("nored_valid", {31'd0, inst_valid}, 32'd1);
        stall = 1'b1;
        tick();
        check_eq("end_hold_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_eq("sb_left", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
